// File: rtl/sd_bus_arbiter.sv
// Arbitrates the SD SPI bus (MOSI/CSn) between the init, read and write engines.
// Optional grant timeout is compiled in with the SD_ARB_TIMEOUT_EN macro.
module sd_bus_arbiter #(
    parameter int GAP_TICKS     = 8,
    parameter int TIMEOUT_TICKS = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sck_en,
    input  logic init_ok,
    input  logic init_req,
    input  logic init_done,
    input  logic init_mosi,
    input  logic init_csn,
    input  logic rd_req,
    input  logic rd_done,
    input  logic rd_mosi,
    input  logic rd_csn,
    input  logic wr_req,
    input  logic wr_done,
    input  logic wr_mosi,
    input  logic wr_csn,
    output logic init_gnt,
    output logic rd_gnt,
    output logic wr_gnt,
    output logic busy,
    output logic err,
    output logic SD_MOSI,
    output logic SD_CSn
);

    localparam int GAP_W = $clog2(GAP_TICKS + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);

    if (GAP_TICKS < 1 || TIMEOUT_TICKS < 1) begin : g_param_check
        $error("sd_bus_arbiter: GAP_TICKS and TIMEOUT_TICKS must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        OWN_INIT = 3'd1,
        OWN_RD   = 3'd2,
        OWN_WR   = 3'd3,
        GAP      = 3'd4
    } state_t;

    state_t           state_r;
    logic [GAP_W-1:0] gap_cnt_r;
    logic             last_wr_r;
    logic             init_gnt_r;
    logic             rd_gnt_r;
    logic             wr_gnt_r;
    logic             busy_r;
    logic             mosi_r;
    logic             csn_r;

    logic own_req_s;
    logic own_done_s;
    logic own_mosi_s;
    logic own_csn_s;
    logic own_s;
    logic to_hit_s;

    // Select the current owner's request, done and bus signals.
    always_comb begin
        own_req_s  = 1'b0;
        own_done_s = 1'b0;
        own_mosi_s = 1'b1;
        own_csn_s  = 1'b1;
        own_s      = 1'b0;
        case (state_r)
            OWN_INIT: begin
                own_req_s  = init_req;
                own_done_s = init_done;
                own_mosi_s = init_mosi;
                own_csn_s  = init_csn;
                own_s      = 1'b1;
            end
            OWN_RD: begin
                own_req_s  = rd_req;
                own_done_s = rd_done;
                own_mosi_s = rd_mosi;
                own_csn_s  = rd_csn;
                own_s      = 1'b1;
            end
            OWN_WR: begin
                own_req_s  = wr_req;
                own_done_s = wr_done;
                own_mosi_s = wr_mosi;
                own_csn_s  = wr_csn;
                own_s      = 1'b1;
            end
            default: begin
                own_req_s  = 1'b0;
                own_done_s = 1'b0;
                own_mosi_s = 1'b1;
                own_csn_s  = 1'b1;
                own_s      = 1'b0;
            end
        endcase
    end

`ifdef SD_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);

    logic [TO_W-1:0] to_cnt_r;
    logic            err_r;

    assign to_hit_s = own_s && sck_en && (to_cnt_r == TO_LAST);
    assign err      = err_r;

    // Grant hold counter; sits at zero outside OWN states so every grant starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r <= {TO_W{1'b0}};
            err_r    <= 1'b0;
        end else begin
            err_r <= to_hit_s && !own_done_s && own_req_s;
            if (!own_s || to_hit_s) begin
                to_cnt_r <= {TO_W{1'b0}};
            end else if (sck_en) begin
                to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
            end else begin
                to_cnt_r <= to_cnt_r;
            end
        end
    end
`else
    assign to_hit_s = 1'b0;
    assign err      = 1'b0;
`endif

    // Arbitration FSM with registered grants, busy and muxed bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            gap_cnt_r  <= {GAP_W{1'b0}};
            last_wr_r  <= 1'b1;
            init_gnt_r <= 1'b0;
            rd_gnt_r   <= 1'b0;
            wr_gnt_r   <= 1'b0;
            busy_r     <= 1'b0;
            mosi_r     <= 1'b1;
            csn_r      <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    mosi_r <= 1'b1;
                    csn_r  <= 1'b1;
                    if (init_req) begin
                        state_r    <= OWN_INIT;
                        init_gnt_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end else if (init_ok && rd_req && (!wr_req || last_wr_r)) begin
                        state_r   <= OWN_RD;
                        rd_gnt_r  <= 1'b1;
                        busy_r    <= 1'b1;
                        last_wr_r <= 1'b0;
                    end else if (init_ok && wr_req) begin
                        state_r   <= OWN_WR;
                        wr_gnt_r  <= 1'b1;
                        busy_r    <= 1'b1;
                        last_wr_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                OWN_INIT, OWN_RD, OWN_WR: begin
                    // Done, abort and timeout all release the same way.
                    if (own_done_s || !own_req_s || to_hit_s) begin
                        state_r    <= GAP;
                        gap_cnt_r  <= {GAP_W{1'b0}};
                        init_gnt_r <= 1'b0;
                        rd_gnt_r   <= 1'b0;
                        wr_gnt_r   <= 1'b0;
                        mosi_r     <= 1'b1;
                        csn_r      <= 1'b1;
                    end else begin
                        mosi_r <= own_mosi_s;
                        csn_r  <= own_csn_s;
                    end
                end
                GAP: begin
                    mosi_r <= 1'b1;
                    csn_r  <= 1'b1;
                    if (sck_en) begin
                        if (gap_cnt_r == GAP_LAST) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            gap_cnt_r <= gap_cnt_r + {{(GAP_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        gap_cnt_r <= gap_cnt_r;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    init_gnt_r <= 1'b0;
                    rd_gnt_r   <= 1'b0;
                    wr_gnt_r   <= 1'b0;
                    busy_r     <= 1'b0;
                    mosi_r     <= 1'b1;
                    csn_r      <= 1'b1;
                end
            endcase
        end
    end

    assign init_gnt = init_gnt_r;
    assign rd_gnt   = rd_gnt_r;
    assign wr_gnt   = wr_gnt_r;
    assign busy     = busy_r;
    assign SD_MOSI  = mosi_r;
    assign SD_CSn   = csn_r;

endmodule
